// File: rtl/eeprom_access_ctrl_if.sv
// CPU-side request/ack bus of the EEPROM access controller.
// The CPU holds a request (with we/addr/din) until it sees the one-cycle ack.
interface eeprom_access_ctrl_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [12:0] cpu_addr;
  logic [7:0]  cpu_din;
  logic [7:0]  cpu_dout;
  logic        cpu_ack;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_din,
    input  cpu_dout, cpu_ack
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_din,
    output cpu_dout, cpu_ack
  );
endinterface

// File: rtl/eeprom_access_ctrl.sv
// Arbitrates CPU byte accesses and HPS load/save ownership of a 13-bit EEPROM, tracks dirty state and autosave.
// Reads ack 3 cycles after cpu_req is taken, writes ack after 2 (posted); CPU stalls while busy or HPS-owned.
module eeprom_access_ctrl #(
  parameter logic [31:0] IDLE_CYCLES = 32'd48_000_000,
  parameter logic [31:0] MAX_BUSY    = 32'd1_000_000
) (
  input  logic                       clk,
  input  logic                       reset_n,
  eeprom_access_ctrl_if.slave        cpu,
  input  logic                       hps_req,
  input  logic                       hps_upload,
  output logic                       hps_grant,
  output logic                       ee_ce,
  output logic                       ee_wr,
  output logic                       ee_rd,
  output logic [12:0]                ee_addr,
  output logic [7:0]                 ee_data,
  input  logic [7:0]                 ee_q,
  input  logic                       ee_ready,
  output logic                       dirty,
  output logic                       save_req,
  output logic                       busy_err
);

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_CAPT,
    WR_ISSUE,
    WR_SETTLE,
    WR_BUSY,
    HPS_OWN
  } state_t;

  state_t      state;
  logic [31:0] busy_cnt;
  logic [31:0] idle_cnt;
  logic [7:0]  dout_q;
  logic        ack_q;

  logic        set_dirty;
  logic        clr_dirty;
  logic        dirty_nxt;
  logic [31:0] idle_nxt;
  logic        save_nxt;

  assign cpu.cpu_dout = dout_q;
  assign cpu.cpu_ack  = ack_q;

  // Chip enable follows reset directly so it is low for the whole reset window.
  assign ee_ce = reset_n;

  always_comb begin
    set_dirty = 1'b0;
    clr_dirty = 1'b0;
    dirty_nxt = dirty;
    idle_nxt  = idle_cnt;
    save_nxt  = 1'b0;

    // The write ack is launched on the WR_ISSUE edge; an upload grant can only start from IDLE.
    set_dirty = (state == WR_ISSUE);
    clr_dirty = (state == IDLE) && hps_req && hps_upload;

    if (set_dirty) begin
      dirty_nxt = 1'b1;
    end else if (clr_dirty) begin
      dirty_nxt = 1'b0;
    end

    if (set_dirty) begin
      idle_nxt = 32'd0;
    end else if (dirty && (idle_cnt != 32'hFFFF_FFFF)) begin
      idle_nxt = idle_cnt + 32'd1;
    end

    save_nxt = dirty_nxt && (idle_nxt >= IDLE_CYCLES);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      busy_cnt  <= 32'd0;
      idle_cnt  <= 32'd0;
      dout_q    <= 8'd0;
      ack_q     <= 1'b0;
      ee_wr     <= 1'b0;
      ee_rd     <= 1'b0;
      ee_addr   <= 13'd0;
      ee_data   <= 8'd0;
      hps_grant <= 1'b0;
      dirty     <= 1'b0;
      save_req  <= 1'b0;
      busy_err  <= 1'b0;
    end else begin
      ack_q    <= 1'b0;
      ee_rd    <= 1'b0;
      ee_wr    <= 1'b0;
      dirty    <= dirty_nxt;
      idle_cnt <= idle_nxt;
      save_req <= save_nxt;

      case (state)
        IDLE: begin
          if (hps_req) begin
            state     <= HPS_OWN;
            hps_grant <= 1'b1;
          end else if (cpu.cpu_req && !ack_q) begin
            // The request is still high during its own ack cycle; do not take it twice.
            ee_addr <= cpu.cpu_addr;
            if (cpu.cpu_we) begin
              ee_data <= cpu.cpu_din;
              ee_wr   <= 1'b1;
              state   <= WR_ISSUE;
            end else begin
              ee_rd   <= 1'b1;
              state   <= RD_ISSUE;
            end
          end
        end

        RD_ISSUE: begin
          state <= RD_CAPT;
        end

        RD_CAPT: begin
          dout_q <= ee_q;
          ack_q  <= 1'b1;
          state  <= IDLE;
        end

        WR_ISSUE: begin
          ack_q <= 1'b1;
          state <= WR_SETTLE;
        end

        WR_SETTLE: begin
          busy_cnt <= 32'd0;
          state    <= WR_BUSY;
        end

        WR_BUSY: begin
          if (ee_ready) begin
            busy_cnt <= 32'd0;
            state    <= IDLE;
          end else if ((busy_cnt + 32'd1) >= MAX_BUSY) begin
            busy_cnt <= 32'd0;
            busy_err <= 1'b1;
            state    <= IDLE;
          end else begin
            busy_cnt <= busy_cnt + 32'd1;
          end
        end

        HPS_OWN: begin
          if (!hps_req) begin
            hps_grant <= 1'b0;
            state     <= IDLE;
          end
        end

        default: begin
          hps_grant <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  ack_not_back_to_back: assert property (@(posedge clk) disable iff (!reset_n) ack_q |=> !ack_q);
  ack_not_while_granted: assert property (@(posedge clk) disable iff (!reset_n) !(ack_q && hps_grant));
  strobes_exclusive: assert property (@(posedge clk) disable iff (!reset_n) !(ee_rd && ee_wr));

endmodule

// File: tb/tb_eeprom_access_ctrl.sv
// Bench for eeprom_access_ctrl: emulated EEPROM, transaction-level reference model, directed scenarios.
module tb_eeprom_access_ctrl;
  localparam logic [31:0] IDLE_N = 32'd100;
  localparam logic [31:0] BUSY_N = 32'd50;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        hps_req = 1'b0;
  logic        hps_upload = 1'b0;
  logic        hps_grant;
  logic        ee_ce, ee_wr, ee_rd;
  logic [12:0] ee_addr;
  logic [7:0]  ee_data;
  logic [7:0]  ee_q = 8'd0;
  logic        ee_ready = 1'b1;
  logic        dirty, save_req, busy_err;

  int vectors = 0;
  int errs = 0;
  bit started = 1'b0;
  int busy_len = 0;
  bit stuck = 1'b0;
  int hold = 0;
  logic [7:0] mem [0:8191];

  eeprom_access_ctrl_if cif();

  eeprom_access_ctrl #(.IDLE_CYCLES(IDLE_N), .MAX_BUSY(BUSY_N)) dut (
    .clk(clk), .reset_n(reset_n), .cpu(cif),
    .hps_req(hps_req), .hps_upload(hps_upload), .hps_grant(hps_grant),
    .ee_ce(ee_ce), .ee_wr(ee_wr), .ee_rd(ee_rd), .ee_addr(ee_addr), .ee_data(ee_data),
    .ee_q(ee_q), .ee_ready(ee_ready),
    .dirty(dirty), .save_req(save_req), .busy_err(busy_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // EEPROM emulation: byte array, ee_q one cycle after ee_rd, ee_ready low busy_len cycles after ee_wr.
  always @(negedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 8192; i++) mem[i] <= 8'(i * 3 + 1);
      mem[16]  <= 8'hA5;
      hold     <= 0;
      ee_ready <= 1'b1;
    end else begin
      if (ee_rd) ee_q <= mem[ee_addr];
      if (ee_wr) mem[ee_addr] <= ee_data;
      hold     <= ee_wr ? busy_len : (hold > 0 ? hold - 1 : 0);
      ee_ready <= !stuck && (ee_wr ? (busy_len == 0) : (hold <= 1));
    end
  end

  // Reference model: a job is accepted when the controller is free, then progresses by age.
  typedef struct packed {
    int          job;   // 0 free, 1 read, 2 write, 3 hps
    int          age;
    logic [12:0] jaddr;
    int          cyc;
    int          wack;
    bit          dirty;
    bit          err;
    bit          ack;
    bit          rdack;
    bit          rd;
    bit          wr;
    bit          grant;
    bit          save;
    logic [7:0]  dout;
    logic [12:0] addr;
    logic [7:0]  data;
  } mstate_t;

  mstate_t m;

  function automatic mstate_t step(input mstate_t s);
    mstate_t n = s;
    n.cyc   = s.cyc + 1;
    n.ack   = 1'b0;
    n.rdack = 1'b0;
    n.rd    = 1'b0;
    n.wr    = 1'b0;
    case (s.job)
      0: begin
        if (hps_req) begin
          n.job   = 3;
          n.grant = 1'b1;
          if (hps_upload) n.dirty = 1'b0;
        end else if (cif.cpu_req && !s.ack) begin
          n.jaddr = cif.cpu_addr;
          n.addr  = cif.cpu_addr;
          n.age   = 1;
          if (cif.cpu_we) begin
            n.job  = 2;
            n.wr   = 1'b1;
            n.data = cif.cpu_din;
          end else begin
            n.job = 1;
            n.rd  = 1'b1;
          end
        end
      end
      1: begin
        n.age = s.age + 1;
        if (n.age == 3) begin
          n.ack   = 1'b1;
          n.rdack = 1'b1;
          n.dout  = mem[s.jaddr];
          n.job   = 0;
        end
      end
      2: begin
        if (s.age == 1) begin
          n.age   = 2;
          n.ack   = 1'b1;
          n.dirty = 1'b1;
          n.wack  = n.cyc;
        end else if (s.age == 2) begin
          n.age = 3;
        end else if (ee_ready) begin
          n.job = 0;
        end else if (s.age - 2 >= int'(BUSY_N)) begin
          n.err = 1'b1;
          n.job = 0;
        end else begin
          n.age = s.age + 1;
        end
      end
      default: begin
        if (!hps_req) begin
          n.job   = 0;
          n.grant = 1'b0;
        end
      end
    endcase
    n.save = n.dirty && ((n.cyc - n.wack) >= int'(IDLE_N));
    return n;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) m <= '0;
    else          m <= step(m);
  end

  always @(negedge clk) begin
    if (started) begin
      chk("cpu_ack", cif.cpu_ack, m.ack);
      chk("ee_rd", ee_rd, m.rd);
      chk("ee_wr", ee_wr, m.wr);
      chk("hps_grant", hps_grant, m.grant);
      chk("dirty", dirty, m.dirty);
      chk("save_req", save_req, m.save);
      chk("busy_err", busy_err, m.err);
      chk("ee_ce", ee_ce, reset_n);
      if (m.rdack) chk("cpu_dout", cif.cpu_dout, m.dout);
      if (m.rd || m.wr) chk("ee_addr", ee_addr, m.addr);
      if (m.wr) chk("ee_data", ee_data, m.data);
    end
  end

  task automatic cpu_go(input logic we, input logic [12:0] a, input logic [7:0] d);
    cif.cpu_req  = 1'b1;
    cif.cpu_we   = we;
    cif.cpu_addr = a;
    cif.cpu_din  = d;
  endtask

  // Waits for cpu_ack; n is the cycle index of the ack (1 = cycle after the first sampling edge).
  task automatic wait_ack(input string name, input int bound, output int n, output int strobe_at, output int strobes);
    n = 0; strobe_at = 0; strobes = 0;
    do begin
      @(negedge clk);
      n++;
      if (ee_rd || ee_wr) begin
        strobes++;
        if (strobe_at == 0) strobe_at = n;
      end
    end while (!cif.cpu_ack && n < bound);
    if (!cif.cpu_ack) begin
      vectors++;
      errs++;
      $display("FAIL %s: no cpu_ack within %0d cycles", name, bound);
    end
    cif.cpu_req = 1'b0;
  endtask

  initial begin
    int n, s, c, k, acks;
    cif.cpu_req = 1'b0; cif.cpu_we = 1'b0; cif.cpu_addr = 13'd0; cif.cpu_din = 8'd0;
    #1 reset_n = 1'b0;
    started = 1'b1;
    #1;
    chk("reset_ctl", {cif.cpu_ack, ee_rd, ee_wr, hps_grant, dirty, save_req, busy_err, ee_ce}, 64'd0);
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Plain reads
    cpu_go(1'b0, 13'h0010, 8'h00);
    wait_ack("rd_a5", 20, n, s, c);
    chk("rd_latency", n, 3);
    chk("rd_strobe_cycle", s, 1);
    chk("rd_strobes", c, 1);
    chk("rd_dout_a5", cif.cpu_dout, 8'hA5);
    @(negedge clk);
    cpu_go(1'b0, 13'h0005, 8'h00);
    wait_ack("rd_5", 20, n, s, c);
    chk("rd2_latency", n, 3);
    chk("rd2_dout", cif.cpu_dout, 8'h10);

    // Write with 20 busy cycles, then a read stalled behind it
    @(negedge clk);
    busy_len = 20;
    cpu_go(1'b1, 13'h1FFF, 8'h3C);
    wait_ack("wr_1fff", 20, n, s, c);
    chk("wr_ack_cycle", n, 2);
    chk("wr_strobe_cycle", s, 1);
    chk("wr_strobes", c, 1);
    chk("wr_dirty", dirty, 1);
    cpu_go(1'b0, 13'h1FFF, 8'h00);
    wait_ack("rd_stalled", 100, n, s, c);
    chk("stalled_rd_latency", n, 23);
    chk("stalled_rd_dout", cif.cpu_dout, 8'h3C);

    // HPS request and CPU read both raised during write busy
    @(negedge clk);
    cpu_go(1'b1, 13'h0123, 8'h77);
    wait_ack("wr_0123", 20, n, s, c);
    hps_req = 1'b1; hps_upload = 1'b0;
    cpu_go(1'b0, 13'h0123, 8'h00);
    k = 2; acks = 0;
    do begin
      @(negedge clk);
      k++;
      if (cif.cpu_ack) acks++;
    end while (!hps_grant && k < 100);
    chk("grant_cycle", k, 23);
    repeat (6) begin
      @(negedge clk);
      if (cif.cpu_ack) acks++;
    end
    chk("acks_while_blocked", acks, 0);
    hps_req = 1'b0;
    wait_ack("rd_after_hps", 20, n, s, c);
    chk("rd_after_hps_latency", n, 4);
    chk("rd_after_hps_dout", cif.cpu_dout, 8'h77);

    // Autosave after IDLE_N idle cycles, cleared by an upload grant
    @(negedge clk);
    busy_len = 0;
    cpu_go(1'b1, 13'h0200, 8'h99);
    wait_ack("wr_0200", 20, n, s, c);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!save_req && k < 300);
    chk("save_delay", k, 100);
    hps_req = 1'b1; hps_upload = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!hps_grant && k < 10);
    chk("upload_grant_cycle", k, 1);
    chk("upload_dirty", dirty, 0);
    chk("upload_save", save_req, 0);
    hps_req = 1'b0; hps_upload = 1'b0;
    repeat (2) @(negedge clk);
    chk("grant_released", hps_grant, 0);

    // Busy timeout with ee_ready stuck low
    stuck = 1'b1;
    cpu_go(1'b1, 13'h0300, 8'h42);
    wait_ack("wr_0300", 20, n, s, c);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!busy_err && k < 200);
    chk("timeout_delay", k, 51);
    stuck = 1'b0;
    cpu_go(1'b0, 13'h0300, 8'h00);
    wait_ack("rd_after_timeout", 20, n, s, c);
    chk("rd_after_timeout_latency", n, 3);
    chk("rd_after_timeout_dout", cif.cpu_dout, 8'h42);
    chk("busy_err_sticky", busy_err, 1);

    // Reset in the middle of write busy
    @(negedge clk);
    busy_len = 20;
    cpu_go(1'b1, 13'h0400, 8'hE1);
    wait_ack("wr_0400", 20, n, s, c);
    repeat (4) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_ctl", {cif.cpu_ack, ee_rd, ee_wr, hps_grant, dirty, save_req, busy_err, ee_ce}, 64'd0);
    chk("midrst_bus", {ee_addr, ee_data, cif.cpu_dout}, 64'd0);
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b1;
    acks = 0;
    repeat (5) begin
      @(negedge clk);
      if (cif.cpu_ack) acks++;
    end
    chk("post_reset_acks", acks, 0);
    chk("post_reset_ce", ee_ce, 1);
    cpu_go(1'b0, 13'h0010, 8'h00);
    wait_ack("rd_after_reset", 20, n, s, c);
    chk("rd_after_reset_latency", n, 3);
    chk("rd_after_reset_dout", cif.cpu_dout, 8'hA5);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
